// File: rtl/imem_pkg.sv
// Shared types and address helpers for the RAM-backed instruction memory.
package imem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic {
        INIT,
        READY
    } state_t;

    // Where rdata comes from: the reset value, the RAM output register, or the error filler.
    typedef enum logic [1:0] {
        RD_ZERO,
        RD_RAM,
        RD_DFLT
    } rd_src_t;

    function automatic int unsigned word_index(input logic [31:0] addr);
        return int'(addr >> 2);
    endfunction

    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] == 2'b00) && (word_index(addr) < depth);
    endfunction

endpackage

// File: rtl/imem_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one synchronous read-first read port.
module imem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; non-blocking writes give read-first on a collision.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/instr_mem_sync.sv
// Instruction memory top: clear-on-reset FSM, fetch req/valid path and loader write handshake.
module instr_mem_sync
    import imem_pkg::*;
#(
    parameter int                DATA_W         = 32,
    parameter int                ADDR_W         = 8,
    parameter int                DEPTH          = 64,
    parameter logic [DATA_W-1:0] DEFAULT_INSTR  = DATA_W'(NOP_INSTR),
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_done,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              fetch_err,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_wdata,
    output logic              prog_ack
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    rd_src_t           rd_src_q;
    logic              rvalid_q;
    logic              prog_ack_q;

    logic              fetch_ok, prog_ok, fetch_acc, prog_acc;
    logic [IDX_W-1:0]  fetch_idx, prog_idx;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    assign init_done   = (state_q == READY);
    assign fetch_ready = init_done;

    assign fetch_ok  = addr_ok(32'(fetch_addr), DEPTH);
    assign prog_ok   = addr_ok(32'(prog_addr), DEPTH);
    assign fetch_idx = IDX_W'(word_index(32'(fetch_addr)));
    assign prog_idx  = IDX_W'(word_index(32'(prog_addr)));

    assign fetch_acc = fetch_req && init_done;
    // An ack in flight blocks re-acceptance of the same held request.
    assign prog_acc  = prog_we && init_done && !prog_ack_q;

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ram_we    = 1'b0;
        ram_waddr = prog_idx;
        ram_wdata = prog_wdata;
        case (state_q)
            INIT: begin
                ram_we    = 1'b1;
                ram_waddr = cnt_q;
                ram_wdata = DEFAULT_INSTR;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY: begin
                ram_we = prog_acc && prog_ok;
            end
            default: state_d = INIT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR_ON_RESET ? INIT : READY;
            cnt_q      <= '0;
            rvalid_q   <= 1'b0;
            rd_src_q   <= RD_ZERO;
            prog_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rvalid_q   <= fetch_acc;
            prog_ack_q <= prog_acc;
            if (fetch_acc) begin
                rd_src_q <= fetch_ok ? RD_RAM : RD_DFLT;
            end
        end
    end

    imem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (fetch_acc && fetch_ok),
        .raddr (fetch_idx),
        .rdata (ram_rdata)
    );

    // The RAM output register only loads on good fetches, so it holds across idle cycles.
    always_comb begin
        rdata = '0;
        case (rd_src_q)
            RD_RAM:  rdata = ram_rdata;
            RD_DFLT: rdata = DEFAULT_INSTR;
            default: rdata = '0;
        endcase
    end

    assign rvalid    = rvalid_q;
    assign fetch_err = rvalid_q && (rd_src_q == RD_DFLT);
    assign prog_ack  = prog_ack_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Self-checking bench: directed scenarios plus a randomized run against an array reference model.
module tb_instr_mem_sync;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        init_done, fetch_ready, rvalid, fetch_err, prog_ack;
    logic        f_req, p_we;
    logic [7:0]  f_addr, p_addr;
    logic [31:0] p_wdata, rdata;

    logic        s_init_done, s_fetch_ready, s_rvalid, s_fetch_err, s_prog_ack;
    logic        s_req, s_we;
    logic [7:0]  s_addr, s_paddr;
    logic [31:0] s_wdata, s_rdata;

    instr_mem_sync dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done),
        .fetch_req(f_req), .fetch_addr(f_addr), .fetch_ready(fetch_ready),
        .rdata(rdata), .rvalid(rvalid), .fetch_err(fetch_err),
        .prog_we(p_we), .prog_addr(p_addr), .prog_wdata(p_wdata), .prog_ack(prog_ack)
    );

    instr_mem_sync #(.DEPTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .init_done(s_init_done),
        .fetch_req(s_req), .fetch_addr(s_addr), .fetch_ready(s_fetch_ready),
        .rdata(s_rdata), .rvalid(s_rvalid), .fetch_err(s_fetch_err),
        .prog_we(s_we), .prog_addr(s_paddr), .prog_wdata(s_wdata), .prog_ack(s_prog_ack)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] model [64];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic ok8(input logic [7:0] a);
        return (a % 4 == 0) && (a / 4 < 64);
    endfunction

    // Counts edges from reset release; both instances must finish their clear on schedule.
    task automatic run_init();
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk);
            #1;
            check("init_done", init_done, 32'(i >= 64));
            check("fetch_ready", fetch_ready, 32'(i >= 64));
            check("init_done32", s_init_done, 32'(i >= 32));
            check("ack_in_init", prog_ack, 0);
            if (i < 64) check("rvalid_in_init", rvalid, 0);
        end
        for (int k = 0; k < 64; k++) model[k] = NOP;
    endtask

    task automatic prog_write(input logic [7:0] a, input logic [31:0] d);
        p_we = 1'b1; p_addr = a; p_wdata = d;
        step();
        check("prog_ack_pulse", prog_ack, 1);
        p_we = 1'b0;
        step();
        check("prog_ack_low", prog_ack, 0);
        if (ok8(a)) model[a / 4] = d;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_init"}, init_done, 0);
        check({tag, "_ready"}, fetch_ready, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_rvalid"}, rvalid, 0);
        check({tag, "_err"}, fetch_err, 0);
        check({tag, "_ack"}, prog_ack, 0);
        check({tag, "_init32"}, s_init_done, 0);
    endtask

    logic [31:0] last_rd, nxt_rd;
    logic        nxt_rv, nxt_err, nxt_ack, pend_ack;

    initial begin
        f_req = 0; f_addr = 0; p_we = 0; p_addr = 0; p_wdata = 0;
        s_req = 0; s_addr = 0; s_we = 0; s_paddr = 0; s_wdata = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");

        // 1: clear sequence timing, then first fetch sees NOP
        step();
        rst_n = 1'b1;
        run_init();
        step();
        f_req = 1; f_addr = 8'h00;
        step();
        f_req = 0;
        check("t1_rvalid", rvalid, 1);
        check("t1_rdata", rdata, NOP);
        check("t1_err", fetch_err, 0);
        step();
        check("t1_rvalid_drop", rvalid, 0);
        check("t1_rdata_hold", rdata, NOP);

        // 2: two writes, then back-to-back fetches
        prog_write(8'h00, 32'h00100193);
        prog_write(8'h04, 32'h0ff00083);
        f_req = 1; f_addr = 8'h00;
        step();
        check("t2_rvalid0", rvalid, 1);
        check("t2_rdata0", rdata, 32'h00100193);
        f_addr = 8'h04;
        step();
        f_req = 0;
        check("t2_rvalid1", rvalid, 1);
        check("t2_rdata1", rdata, 32'h0ff00083);
        step();
        check("t2_idle", rvalid, 0);

        // 3: DEPTH=32 instance, misaligned and out-of-range fetches, dropped write
        s_req = 1; s_addr = 8'h02;
        step();
        check("t3_mis_rvalid", s_rvalid, 1);
        check("t3_mis_err", s_fetch_err, 1);
        check("t3_mis_rdata", s_rdata, NOP);
        s_addr = 8'h80;
        step();
        s_req = 0;
        check("t3_oor_rvalid", s_rvalid, 1);
        check("t3_oor_err", s_fetch_err, 1);
        check("t3_oor_rdata", s_rdata, NOP);
        s_we = 1; s_paddr = 8'h80; s_wdata = 32'hdeadbeef;
        step();
        check("t3_oor_ack", s_prog_ack, 1);
        check("t3_err_clear", s_fetch_err, 0);
        s_we = 0;
        s_req = 1; s_addr = 8'h00;
        step();
        check("t3_word0", s_rdata, NOP);
        check("t3_word0_err", s_fetch_err, 0);
        s_addr = 8'h7c;
        step();
        s_req = 0;
        check("t3_last", s_rdata, NOP);
        check("t3_last_err", s_fetch_err, 0);

        // 4: write and fetch of the same word in one cycle reads the old word
        f_req = 1; f_addr = 8'h14;
        p_we = 1; p_addr = 8'h14; p_wdata = 32'hfe0008e3;
        step();
        f_req = 0; p_we = 0;
        check("t4_old", rdata, NOP);
        check("t4_ack", prog_ack, 1);
        step();
        f_req = 1; f_addr = 8'h14;
        step();
        f_req = 0;
        check("t4_new", rdata, 32'hfe0008e3);

        // 5: async reset mid-cycle clears outputs; reset during INIT restarts the full clear
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async");
        step();
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_init");

        // 6: write held from reset release is taken once, after init_done
        step();
        p_we = 1; p_addr = 8'h20; p_wdata = 32'h12345678;
        rst_n = 1'b1;
        run_init();
        @(posedge clk); #1;
        check("t6_ack", prog_ack, 1);
        @(posedge clk); #1;
        check("t6_no_reaccept", prog_ack, 0);
        p_we = 0;
        model[8] = 32'h12345678;
        step();
        check("t6_ack_stays_low", prog_ack, 0);
        f_req = 1; f_addr = 8'h20;
        step();
        f_req = 0;
        check("t6_readback", rdata, 32'h12345678);
        check("t6_readback_err", fetch_err, 0);
        last_rd = 32'h12345678;
        pend_ack = 1'b0;

        // randomized traffic against the array model (read-first, drop bad writes)
        for (int c = 0; c < 600; c++) begin
            f_req   = 1'($urandom_range(0, 1));
            f_addr  = ($urandom_range(0, 9) < 7) ? 8'(4 * $urandom_range(0, 63)) : 8'($urandom);
            p_we    = ($urandom_range(0, 2) == 0);
            p_addr  = ($urandom_range(0, 9) < 8) ? 8'(4 * $urandom_range(0, 15)) : 8'($urandom);
            p_wdata = $urandom;
            nxt_rv  = f_req;
            nxt_err = f_req && !ok8(f_addr);
            nxt_rd  = !f_req ? last_rd : (ok8(f_addr) ? model[f_addr / 4] : NOP);
            nxt_ack = p_we && !pend_ack;
            if (nxt_ack && ok8(p_addr)) model[p_addr / 4] = p_wdata;
            step();
            check("rnd_rvalid", rvalid, nxt_rv);
            check("rnd_err", fetch_err, nxt_err);
            check("rnd_rdata", rdata, nxt_rd);
            check("rnd_ack", prog_ack, nxt_ack);
            pend_ack = nxt_ack;
            last_rd  = nxt_rd;
        end
        f_req = 0; p_we = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
